gray_dither_pack: RTL and testbench

Converts a stream of n-bit grayscale pixels (the output of the RGB-to-gray stage) into 1-bit-per-pixel monochrome using 4x4 Bayer ordered dithering, then packs 8 horizontally adjacent pixels into one byte. It sits directly downstream of the gray converter and feeds a monochrome display or framebuffer writer. Position tracking, dithering thresholds and packing are internal. Both sides use valid/ready handshakes.

---
 rtl/gray_dither_pack.sv | 158 +++++++++++++++
 tb/tb_gray_dither_pack.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_dither_pack.sv
// gray_dither_pack: 4x4 Bayer ordered dithering of an N-bit gray stream to
// 1 bit per pixel, packed 8 pixels per byte (MSB = leftmost pixel), with
// line/frame markers and valid/ready handshakes on both sides.
module gray_dither_pack #(
    parameter int N = 8,
    parameter int W = 128,
    parameter int H = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] y,
    input  logic         y_valid,
    input  logic         sof,
    output logic         y_ready,
    output logic [7:0]   d,
    output logic         d_valid,
    input  logic         d_ready,
    output logic         eol,
    output logic         eof
);

    localparam int PXW = $clog2(W);
    localparam int PYW = ($clog2(H) < 2) ? 2 : $clog2(H);
    localparam int CW  = N + 6;

    // Bayer 4x4 threshold matrix lookup, indexed by (row, column) mod 4.
    function automatic logic [3:0] bayer_thr(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] t;
        case ({row, col})
            4'h0:    t = 4'd0;
            4'h1:    t = 4'd8;
            4'h2:    t = 4'd2;
            4'h3:    t = 4'd10;
            4'h4:    t = 4'd12;
            4'h5:    t = 4'd4;
            4'h6:    t = 4'd14;
            4'h7:    t = 4'd6;
            4'h8:    t = 4'd3;
            4'h9:    t = 4'd11;
            4'hA:    t = 4'd1;
            4'hB:    t = 4'd9;
            4'hC:    t = 4'd15;
            4'hD:    t = 4'd7;
            4'hE:    t = 4'd13;
            4'hF:    t = 4'd5;
            default: t = 4'd0;
        endcase
        return t;
    endfunction

    logic [PXW-1:0] px_r;
    logic [PYW-1:0] py_r;
    logic [7:0]     acc_r;
    logic [7:0]     d_r;
    logic           d_valid_r;
    logic           eol_r;
    logic           eof_r;

    logic           accept_s;
    logic [PXW-1:0] cur_x_s;
    logic [PYW-1:0] cur_y_s;
    logic [3:0]     thr_s;
    logic [CW-1:0]  lhs_s;
    logic [CW-1:0]  rhs_s;
    logic           pix_bit_s;
    logic [7:0]     base_acc_s;
    logic [7:0]     byte_s;
    logic           last_in_byte_s;
    logic           line_end_s;
    logic           frame_end_s;
    logic [PXW-1:0] next_x_s;
    logic [PYW-1:0] next_y_s;

    // Upstream may push whenever no byte is stuck waiting for downstream.
    always_comb begin
        y_ready  = !d_valid_r || d_ready;
        accept_s = y_valid && y_ready;
    end

    // Position of the offered pixel, its dithered bit and the byte it completes.
    always_comb begin
        if (sof) begin
            cur_x_s    = '0;
            cur_y_s    = '0;
            base_acc_s = 8'h00;
        end else begin
            cur_x_s    = px_r;
            cur_y_s    = py_r;
            base_acc_s = acc_r;
        end
        thr_s = bayer_thr(cur_y_s[1:0], cur_x_s[1:0]);
        // 32*y >= (2t+1)*2^N, both sides exact at N+6 bits
        lhs_s     = {1'b0, y, 5'b00000};
        rhs_s     = {1'b0, thr_s, 1'b1, {N{1'b0}}};
        pix_bit_s = (lhs_s >= rhs_s);
        byte_s    = base_acc_s | ({7'b0000000, pix_bit_s} << (3'd7 - cur_x_s[2:0]));
        last_in_byte_s = (cur_x_s[2:0] == 3'd7);
        line_end_s     = (cur_x_s == PXW'(W - 1));
        frame_end_s    = line_end_s && (cur_y_s == PYW'(H - 1));
        if (line_end_s) begin
            next_x_s = '0;
            if (cur_y_s == PYW'(H - 1)) begin
                next_y_s = '0;
            end else begin
                next_y_s = cur_y_s + PYW'(1);
            end
        end else begin
            next_x_s = cur_x_s + PXW'(1);
            next_y_s = cur_y_s;
        end
    end

    // Advance the pixel position and shift the dithered bit into the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_r  <= '0;
            py_r  <= '0;
            acc_r <= 8'h00;
        end else if (accept_s) begin
            px_r <= next_x_s;
            py_r <= next_y_s;
            if (last_in_byte_s) begin
                acc_r <= 8'h00;
            end else begin
                acc_r <= byte_s;
            end
        end else begin
            px_r  <= px_r;
            py_r  <= py_r;
            acc_r <= acc_r;
        end
    end

    // Output byte register: load on the 8th pixel, hold while stalled, retire on d_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r       <= 8'h00;
            d_valid_r <= 1'b0;
            eol_r     <= 1'b0;
            eof_r     <= 1'b0;
        end else if (accept_s && last_in_byte_s) begin
            d_r       <= byte_s;
            d_valid_r <= 1'b1;
            eol_r     <= line_end_s;
            eof_r     <= frame_end_s;
        end else if (d_ready) begin
            d_valid_r <= 1'b0;
        end else begin
            d_valid_r <= d_valid_r;
        end
    end

    assign d       = d_r;
    assign d_valid = d_valid_r;
    assign eol     = eol_r;
    assign eof     = eof_r;

endmodule

// File: tb/tb_gray_dither_pack.sv
// Self-checking bench for gray_dither_pack (N=8, W=16, H=4) using a
// behavioural dithering model and known flat-field byte patterns.
module tb_gray_dither_pack;

    localparam int TN = 8;
    localparam int TW = 16;
    localparam int TH = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  y;
    logic        y_valid;
    logic        sof;
    logic        y_ready;
    logic [7:0]  d;
    logic        d_valid;
    logic        d_ready;
    logic        eol;
    logic        eof;

    int checks;
    int errors;

    // behavioural model state
    int         mx;
    int         my;
    logic [7:0] macc;
    int         bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic       accepted;

    gray_dither_pack #(.N(TN), .W(TW), .H(TH)) dut (
        .clk     (clk),
        .rst     (rst),
        .y       (y),
        .y_valid (y_valid),
        .sof     (sof),
        .y_ready (y_ready),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .eol     (eol),
        .eof     (eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_clear();
        mx   = 0;
        my   = 0;
        macc = 8'h00;
        exp_q.delete();
        got_q.delete();
    endtask

    // Model of one accepted pixel: threshold compare in plain integers.
    task automatic model_accept(input logic [7:0] yv, input logic s);
        int t;
        int lhs;
        int rhs;
        if (s) begin
            mx   = 0;
            my   = 0;
            macc = 8'h00;
        end
        t   = bayer[my % 4][mx % 4];
        lhs = 32 * int'(yv);
        rhs = (2 * t + 1) * (1 << TN);
        if (lhs >= rhs) macc[7 - (mx % 8)] = 1'b1;
        if ((mx % 8) == 7) begin
            exp_q.push_back({macc, (mx == TW - 1), (mx == TW - 1) && (my == TH - 1)});
            macc = 8'h00;
        end
        mx = mx + 1;
        if (mx == TW) begin
            mx = 0;
            my = my + 1;
            if (my == TH) my = 0;
        end
    endtask

    // One clock cycle: drive at posedge+1, observe at negedge, return at posedge+1.
    task automatic step(input logic v, input logic [7:0] yv, input logic s, input logic r);
        y_valid = v;
        y       = yv;
        sof     = s;
        d_ready = r;
        @(negedge clk);
        accepted = v && y_ready;
        if (accepted) model_accept(yv, s);
        if (d_valid && r) got_q.push_back({d, eol, eof});
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] yv, input logic s, input logic r);
        int n;
        n = 0;
        do begin
            step(1'b1, yv, s, r);
            n++;
        end while (!accepted && n < 50);
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pixel not accepted after %0d cycles", n);
        end
    endtask

    task automatic drain();
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        y_valid = 1'b0;
        sof     = 1'b0;
        d_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        y_valid = 1'b0;
        sof     = 1'b0;
        d_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++; if (d !== 8'h00)     begin errors++; $display("FAIL reset_d: got %h expected 00", d); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b expected 0", d_valid); end
        checks++; if (eol !== 1'b0)     begin errors++; $display("FAIL reset_eol: got %b expected 0", eol); end
        checks++; if (eof !== 1'b0)     begin errors++; $display("FAIL reset_eof: got %b expected 0", eof); end
        checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL reset_y_ready: got %b expected 1", y_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Flat frame: compare against the known per-row pattern and the model.
    task automatic test_flat(input logic [7:0] yv, input logic use_sof,
                             input logic [7:0] r0, input logic [7:0] r1,
                             input logic [7:0] r2, input logic [7:0] r3);
        logic [7:0] rows [4];
        logic [9:0] want;
        int n;
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < TW * TH; i++) send_pixel(yv, use_sof && (i == 0), 1'b1);
        drain();
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL flat_%h_count: got %0d bytes expected 8", yv, got_q.size());
        end
        n = (got_q.size() < 8) ? got_q.size() : 8;
        for (int k = 0; k < n; k++) begin
            want = {rows[k / 2], (k % 2) == 1, k == 7};
            checks++;
            if (got_q[k] !== want) begin
                errors++;
                $display("FAIL flat_%h_byte%0d: got d=%h eol=%b eof=%b expected d=%h eol=%b eof=%b",
                         yv, k, got_q[k][9:2], got_q[k][1], got_q[k][0], want[9:2], want[1], want[0]);
            end
            checks++;
            if (k < exp_q.size() && got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL flat_%h_model%0d: got %h expected %h", yv, k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pattern [8] = '{8'hAA, 8'hAA, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'h55};
        logic [9:0] want;
        int n;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) send_pixel(8'd128, i == 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            y_valid = 1'b1;
            y       = 8'd128;
            sof     = 1'b0;
            d_ready = 1'b0;
            @(negedge clk);
            checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL stall_d_valid%0d: got %b expected 1", c, d_valid); end
            checks++; if (d !== 8'hAA)      begin errors++; $display("FAIL stall_d%0d: got %h expected aa", c, d); end
            checks++; if (eol !== 1'b0 || eof !== 1'b0) begin errors++; $display("FAIL stall_flags%0d: got eol=%b eof=%b expected 0 0", c, eol, eof); end
            checks++; if (y_ready !== 1'b0) begin errors++; $display("FAIL stall_y_ready%0d: got %b expected 0", c, y_ready); end
            if (y_ready) model_accept(8'd128, 1'b0);
            @(posedge clk);
            #1;
        end
        for (int i = 8; i < TW * TH; i++) send_pixel(8'd128, 1'b0, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes expected 8", got_q.size());
        end
        n = (got_q.size() < 8) ? got_q.size() : 8;
        for (int k = 0; k < n; k++) begin
            want = {pattern[k], (k % 2) == 1, k == 7};
            checks++;
            if (got_q[k] !== want) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h expected %h", k, got_q[k], want);
            end
        end
    endtask

    task automatic test_sof_midline();
        do_reset();
        for (int i = 0; i < 5; i++) send_pixel(8'd255, 1'b0, 1'b1);
        send_pixel(8'd128, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_pixel(8'd128, 1'b0, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL sof_mid_count: got %0d bytes expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'hAA, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL sof_mid_byte: got %h expected %h", got_q[0], {8'hAA, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_random();
        logic       pend;
        logic [7:0] pend_y;
        logic       pend_s;
        logic       v;
        logic       r;
        int n;
        exp_q.delete();
        got_q.delete();
        pend   = 1'b0;
        pend_y = 8'h00;
        pend_s = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                pend_y = 8'($urandom_range(0, 255));
                pend_s = ($urandom_range(0, 39) == 0);
            end
            v = pend || ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            step(v, pend_y, pend_s, r);
            pend = v && !accepted;
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rand_byte%0d: got d=%h eol=%b eof=%b expected d=%h eol=%b eof=%b",
                         k, got_q[k][9:2], got_q[k][1], got_q[k][0], exp_q[k][9:2], exp_q[k][1], exp_q[k][0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 16; i++) send_pixel(8'd255, i == 0, 1'b1);
        y_valid = 1'b0;
        d_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (d_valid !== 1'b1 || d !== 8'hFF) begin
            errors++;
            $display("FAIL pre_reset_pending: got d_valid=%b d=%h expected 1 ff", d_valid, d);
        end
        rst     = 1'b1;
        y_valid = 1'b1;
        y       = 8'd255;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (d !== 8'h00 || d_valid !== 1'b0 || eol !== 1'b0 || eof !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got d=%h dv=%b eol=%b eof=%b expected 00 0 0 0", d, d_valid, eol, eof);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        y_valid = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) send_pixel(8'd128, 1'b0, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL post_reset_count: got %0d bytes expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'hAA, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL post_reset_byte: got %h expected %h", got_q[0], {8'hAA, 1'b0, 1'b0});
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        y        = 8'h00;
        y_valid  = 1'b0;
        sof      = 1'b0;
        d_ready  = 1'b0;
        accepted = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_flat(8'd0,   1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        test_flat(8'd255, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        test_flat(8'd128, 1'b1, 8'hAA, 8'h55, 8'hAA, 8'h55);
        test_flat(8'd128, 1'b0, 8'hAA, 8'h55, 8'hAA, 8'h55);
        test_flat(8'd64,  1'b1, 8'hAA, 8'h00, 8'hAA, 8'h00);
        test_backpressure();
        test_sof_midline();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
